// File: rtl/frame_buf_master.sv
// Avalon-MM master: streams samples into a circular DDR buffer and reads back the latest frame.
// Optional feature: define FRAME_RD_PRIORITY_EN to give frame reads priority over writes during READ.
module frame_buf_master #(
    parameter int BUF_LEN   = 512,
    parameter int FRAME_LEN = 160,
    parameter int BASE_ADDR = 0,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     frame_start,
    output logic                     frame_busy,
    output logic                     frame_done,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        ddr_addr,
    output logic                     ddr_read,
    output logic                     ddr_write,
    output logic signed [DATA_W-1:0] ddr_writedata,
    input  logic signed [DATA_W-1:0] ddr_readdata,
    input  logic                     ddr_readdatavalid,
    input  logic                     ddr_waitrequest
);
    localparam int PTR_W  = $clog2(BUF_LEN);
    localparam int FILL_W = PTR_W + 1;
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]               state;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [FILL_W-1:0]        fill;
    logic                     hold_full;
    logic signed [DATA_W-1:0] hold_data;
    logic [CNT_W-1:0]         loaded;
    logic [CNT_W-1:0]         received;

    logic                     slot_free;
    logic                     wr_acc;
    logic                     in_acc;
    logic                     start_ok;
    logic                     wr_want;
    logic                     rd_want;
    logic                     issue_wr;
    logic                     issue_rd;
    logic [PTR_W-1:0]         start_ptr;
    logic [PTR_W-1:0]         rd_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]         loaded_nxt;
    logic                     vld_p0;

    always_comb begin
        slot_free = !(ddr_read || ddr_write) || !ddr_waitrequest;
        wr_acc    = ddr_write && !ddr_waitrequest;
`ifdef FRAME_RD_PRIORITY_EN
        in_ready  = !rst && !hold_full && (state != S_READ);
`else
        in_ready  = !rst && !hold_full;
`endif
        in_acc    = in_valid && in_ready;
        start_ok  = (state == S_IDLE) && frame_start && (fill >= FILL_W'(FRAME_LEN));
        start_ptr = wr_ptr - PTR_W'(FRAME_LEN);
        // a write is pending if held but not yet in the slot, or arriving this cycle
        wr_want   = (hold_full && !ddr_write) || in_acc;
        wr_data   = hold_full ? hold_data : in_data;
        rd_want   = (state == S_READ) || start_ok;
        rd_addr   = start_ok ? start_ptr : rd_ptr;
`ifdef FRAME_RD_PRIORITY_EN
        issue_rd  = slot_free && rd_want;
        issue_wr  = slot_free && wr_want && !rd_want;
`else
        issue_wr  = slot_free && wr_want;
        issue_rd  = slot_free && rd_want && !wr_want;
`endif
        loaded_nxt = (start_ok ? '0 : loaded) + CNT_W'(issue_rd);
        vld_p0     = ddr_readdatavalid && (state != S_IDLE);
        frame_busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (in_acc) begin
            hold_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            hold_full     <= 1'b0;
            loaded        <= '0;
            received      <= '0;
            ddr_read      <= 1'b0;
            ddr_write     <= 1'b0;
            ddr_addr      <= '0;
            ddr_writedata <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            frame_done    <= 1'b0;
        end else begin
            if (in_acc) begin
                hold_full <= 1'b1;
            end else if (wr_acc) begin
                hold_full <= 1'b0;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (fill != FILL_W'(BUF_LEN)) begin
                    fill <= fill + FILL_W'(1);
                end
            end

            // command slot: reload only when empty or its command is taken
            if (issue_wr) begin
                ddr_write     <= 1'b1;
                ddr_read      <= 1'b0;
                ddr_addr      <= ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr);
                ddr_writedata <= wr_data;
            end else if (issue_rd) begin
                ddr_read  <= 1'b1;
                ddr_write <= 1'b0;
                ddr_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(rd_addr);
            end else if (slot_free) begin
                ddr_read  <= 1'b0;
                ddr_write <= 1'b0;
            end

            if (start_ok || state == S_READ) begin
                rd_ptr <= issue_rd ? rd_addr + PTR_W'(1) : rd_addr;
                loaded <= loaded_nxt;
                state  <= (loaded_nxt == CNT_W'(FRAME_LEN)) ? S_DRAIN : S_READ;
            end else if (state == S_DRAIN && received == CNT_W'(FRAME_LEN)) begin
                state <= S_IDLE;
            end

            if (start_ok) begin
                received <= '0;
            end else if (vld_p0) begin
                received <= received + CNT_W'(1);
            end

            // output stage: read return registered once
            out_valid  <= vld_p0;
            frame_done <= vld_p0 && (received == CNT_W'(FRAME_LEN - 1));
            if (vld_p0) begin
                out_data <= ddr_readdata;
            end
        end
    end
endmodule

// File: tb/tb_frame_buf_master.sv
// Directed bench for frame_buf_master with a one-cycle-latency Avalon memory model.
module tb_frame_buf_master;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               frame_start = 1'b0;
    logic               frame_busy;
    logic               frame_done;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic [15:0]        ddr_addr;
    logic               ddr_read;
    logic               ddr_write;
    logic signed [15:0] ddr_writedata;
    logic signed [15:0] ddr_readdata = '0;
    logic               ddr_readdatavalid = 1'b0;
    logic               ddr_waitrequest = 1'b0;

    frame_buf_master dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .frame_start(frame_start), .frame_busy(frame_busy), .frame_done(frame_done),
        .out_data(out_data), .out_valid(out_valid), .ddr_addr(ddr_addr), .ddr_read(ddr_read),
        .ddr_write(ddr_write), .ddr_writedata(ddr_writedata), .ddr_readdata(ddr_readdata),
        .ddr_readdatavalid(ddr_readdatavalid), .ddr_waitrequest(ddr_waitrequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model
    logic signed [15:0] mem [0:511];
    int wexp = 0, waddr_err = 0, rd_seen = 0, stall_at = 0, stall_left = 0;
    always @(posedge clk) begin
        ddr_readdatavalid <= ddr_read && !ddr_waitrequest;
        if (ddr_read && !ddr_waitrequest) ddr_readdata <= mem[ddr_addr[8:0]];
        if (ddr_write && !ddr_waitrequest) mem[ddr_addr[8:0]] <= ddr_writedata;
        if (rst) wexp <= 0;
        else if (ddr_write && !ddr_waitrequest) begin
            if (int'(ddr_addr) != wexp) waddr_err <= waddr_err + 1;
            wexp <= (wexp + 1) % 512;
        end
        if (frame_start) rd_seen <= 0;
        else if (ddr_read && !ddr_waitrequest) rd_seen <= rd_seen + 1;
        if (ddr_read && !ddr_waitrequest && rd_seen + 1 == stall_at) begin
            stall_left      <= 3;
            ddr_waitrequest <= 1'b1;
        end else begin
            if (stall_left > 0) stall_left <= stall_left - 1;
            ddr_waitrequest <= (stall_left > 1);
        end
    end

    // protocol monitors
    int both_err = 0, hold_err = 0;
    logic p_wait = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [15:0] p_addr = '0;
    logic signed [15:0] p_wd = '0;
    always @(negedge clk) begin
        if (ddr_read && ddr_write) both_err <= both_err + 1;
        if (p_wait && (p_rd != ddr_read || p_wr != ddr_write || p_addr != ddr_addr || p_wd != ddr_writedata))
            hold_err <= hold_err + 1;
        p_wait <= ddr_waitrequest && (ddr_read || ddr_write);
        p_rd   <= ddr_read;
        p_wr   <= ddr_write;
        p_addr <= ddr_addr;
        p_wd   <= ddr_writedata;
    end

    int n_checks = 0, n_fail = 0;
    int oq[$], rq[$];
    int t_start, t_rd, t_ov, t_done, t_idle, done_idx;
    bit busy_seen;

    typedef struct {
        int n_wr;
        bit run;
        int fa;
        int fv;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_frame_busy"}, int'(frame_busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_ddr_read"}, int'(ddr_read), 0);
        check({tag, "_ddr_write"}, int'(ddr_write), 0);
        check({tag, "_ddr_addr"}, int'(ddr_addr), 0);
        check({tag, "_ddr_writedata"}, int'(ddr_writedata), 0);
    endtask

    task automatic write_samples(input int base, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            in_data  = 16'(base + i);
            in_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (w >= 400) check("in_ready_timeout", int'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit expect_run, input int stop_after, input int budget);
        repeat (4) @(posedge clk);
        oq.delete();
        rq.delete();
        t_rd = -1; t_ov = -1; t_done = -1; t_idle = -1; done_idx = -1; busy_seen = 0;
        #1;
        frame_start = 1'b1;
        t_start = cyc;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ddr_read && !ddr_waitrequest) rq.push_back(int'(ddr_addr));
            if (ddr_read && t_rd < 0) t_rd = cyc;
            if (out_valid) begin
                oq.push_back(int'(out_data));
                if (t_ov < 0) t_ov = cyc;
            end
            if (frame_done) begin
                done_idx = oq.size();
                t_done = cyc;
            end
            if (frame_busy) busy_seen = 1;
            else if (busy_seen && t_idle < 0) t_idle = cyc;
            if (stop_after > 0 && oq.size() >= stop_after) break;
            if (expect_run && t_idle >= 0) break;
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
        frame_start = 1'b0;
        if (expect_run && stop_after == 0) check("frame_complete", int'(t_idle >= 0), 1);
    endtask

    task automatic check_frame(input string tag, input int fa, input int fv);
        int err = 0;
        check({tag, "_busy_seen"}, int'(busy_seen), 1);
        check({tag, "_out_count"}, oq.size(), 160);
        check({tag, "_read_count"}, rq.size(), 160);
        check({tag, "_done_beat"}, done_idx, 160);
        if (oq.size() > 0) begin
            check({tag, "_first_val"}, oq[0], fv);
            check({tag, "_last_val"}, oq[oq.size()-1], fv + 159);
        end
        if (rq.size() > 0) check({tag, "_first_addr"}, rq[0], fa);
        for (int i = 0; i < oq.size() && i < 160; i++) if (oq[i] != fv + i) err++;
        for (int i = 0; i < rq.size() && i < 160; i++) if (rq[i] != (fa + i) % 512) err++;
        check({tag, "_order_errors"}, err, 0);
    endtask

    task automatic check_noframe(input string tag);
        check({tag, "_busy_seen"}, int'(busy_seen), 0);
        check({tag, "_read_count"}, rq.size(), 0);
        check({tag, "_out_count"}, oq.size(), 0);
    endtask

    initial begin
        int err;
        int ov_cnt;
        vecs[0] = '{200, 1'b1, 40, 40};
        vecs[1] = '{100, 1'b0, 0, 0};
        vecs[2] = '{600, 1'b1, 440, 440};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", int'(in_ready), 1);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            write_samples(0, vecs[v].n_wr);
            run_frame(vecs[v].run, 0, vecs[v].run ? 400 : 20);
            if (vecs[v].run) begin
                check_frame($sformatf("vec%0d", v), vecs[v].fa, vecs[v].fv);
                check($sformatf("vec%0d_t_first_read", v), t_rd - t_start, 1);
                check($sformatf("vec%0d_t_first_out", v), t_ov - t_start, 3);
                check($sformatf("vec%0d_t_done", v), t_done - t_start, 162);
                check($sformatf("vec%0d_t_idle", v), t_idle - t_start, 163);
            end else begin
                check_noframe($sformatf("vec%0d", v));
            end
        end

        // writes streaming during a frame read, first sample accepted with frame_start
        fork
            run_frame(1'b1, 0, 1500);
            begin
                wait (frame_start == 1'b1);
                write_samples(2000, 200);
            end
        join
        repeat (6) @(posedge clk);
        check_frame("concurrent", 440, 440);
        err = 0;
        for (int i = 0; i < 200; i++) if (int'(mem[(88 + i) % 512]) != 2000 + i) err++;
        check("concurrent_mem_errors", err, 0);
        check("concurrent_waddr_errors", waddr_err, 0);
        check("concurrent_rw_overlap", both_err, 0);

        // waitrequest stall after the 10th read
        stall_at = 10;
        run_frame(1'b1, 0, 800);
        stall_at = 0;
        check_frame("stall", 128, 2040);
        check("stall_t_done", t_done - t_start, 165);
        check("stall_hold_errors", hold_err, 0);

        // reset after the 50th output beat
        run_frame(1'b1, 50, 800);
        check("midrst_out_count", oq.size(), 50);
        if (oq.size() >= 50) check("midrst_val50", oq[49], 2089);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrst");
        rst = 1'b0;
        ov_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("midrst_late_out_valid", ov_cnt, 0);
        run_frame(1'b0, 0, 20);
        check_noframe("midrst_empty");
        write_samples(1000, 159);
        run_frame(1'b0, 0, 20);
        check_noframe("midrst_159");
        write_samples(1159, 1);
        run_frame(1'b1, 0, 400);
        check_frame("midrst_160", 0, 1000);

        check("final_rw_overlap", both_err, 0);
        check("final_waddr_errors", waddr_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/frame_buf_master.md
# frame_buf_master

Avalon-MM master that sits directly upstream of the 16-bit DDR3 memory port in the LPC datapath. It streams incoming signed audio samples into a circular buffer in memory, one write per sample. On request, it reads back the most recent FRAME_LEN samples in order as an output stream for the LPC analysis stage. It never issues a read and a write in the same cycle, and it obeys waitrequest on every command.

## Interface
- BUF_LEN, 512: circular buffer depth in words; power of two; must satisfy BUF_LEN ≥ 2·FRAME_LEN.
- FRAME_LEN, 160: samples returned per frame request.
- BASE_ADDR, 0: word address of buffer entry 0.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  16  signed sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- frame_start  in  1  single-cycle request to read the latest frame.
- frame_busy  out  1  frame read in progress.
- frame_done  out  1  one-cycle pulse, coincident with the last out_valid.
- out_data  out  16  signed frame sample.
- out_valid  out  1  out_data valid; no backpressure.
- ddr_addr  out  16  word address = BASE_ADDR + pointer.
- ddr_read / ddr_write  out  1  registered commands.
- ddr_writedata  out  16  signed write data.
- ddr_readdata  in  16  signed read data.
- ddr_readdatavalid  in  1  read data valid.
- ddr_waitrequest  in  1  command not accepted this cycle.

## Operation
- **Reset values.**
  - All outputs 0; in_ready is 0 while rst is high.
  - Internal state: wr_ptr=0, fill=0, hold_full=0, FSM=IDLE.
- **Write path.**
  - A one-entry holding register, with in_ready = !rst && !hold_full.
  - When a sample is accepted, it is stored and hold_full is set.
  - The write command presents ddr_addr=wr_ptr and ddr_writedata=sample.
  - On acceptance (ddr_write && !ddr_waitrequest):
    - wr_ptr ← (wr_ptr+1) mod BUF_LEN;
    - fill saturates at BUF_LEN;
    - hold_full clears.
- **Command slot.**
  - A single registered command slot drives ddr_read, ddr_write and ddr_addr.
  - A new command loads only when the slot is empty or its current command is accepted this cycle.
  - While ddr_waitrequest is high, the command, address and data are held unchanged.
  - Invariant: ddr_read && ddr_write is never 1.
- **Arbitration.** A pending write wins over a pending read (default; see Configuration).
- **FSM.**
  - IDLE → READ on frame_start when fill ≥ FRAME_LEN. The block latches rd_ptr = (wr_ptr − FRAME_LEN) mod BUF_LEN and clears the issued and received counters.
  - frame_start is ignored in READ or DRAIN, or when fill < FRAME_LEN.
  - READ: issue reads at rd_ptr. On each acceptance, rd_ptr increments mod BUF_LEN and issued increments. When issued reaches FRAME_LEN → DRAIN.
  - DRAIN: wait until received reaches FRAME_LEN → IDLE.
  - received counts ddr_readdatavalid pulses only in READ or DRAIN. Pulses in IDLE are discarded.
- **Output stream.**
  - out_data and out_valid are ddr_readdata and ddr_readdatavalid registered once, gated by state.
  - frame_done is high together with the FRAME_LEN-th out_valid.
  - frame_busy = (state ≠ IDLE).
- **Data ordering.**
  - Samples come out oldest first.
  - Writes continue during a frame read. They cannot overwrite the frame because BUF_LEN ≥ 2·FRAME_LEN.

## Timing
- Sample accepted at T → ddr_write high at T+1 → in_ready high again at T+2 if there is no waitrequest. Sustained rate is 1 sample per 2 cycles.
- frame_start at T with no pending writes:
  - first ddr_read at T+1;
  - reads back-to-back, last read at T+FRAME_LEN;
  - first out_valid at T+3;
  - last out_valid and frame_done at T+FRAME_LEN+2;
  - frame_busy falls at T+FRAME_LEN+3.
- Each cycle waitrequest is high, or a write wins arbitration, adds one cycle to the read sequence.
- A frame_start in the same cycle as a sample acceptance uses the wr_ptr value before that acceptance.
- rst mid-frame: the next cycle is in reset state, and outstanding read returns produce no out_valid.

## Configuration
- FRAME_RD_PRIORITY_EN
  - Defined: during READ, read issue has priority and in_ready is forced to 0. Frame latency is exactly as in Timing regardless of input traffic.
  - Undefined (default): the pending write has priority and in_ready behaves as in Operation.

## Test plan
- Reset, write 200 samples with value i, then frame_start → 160 out_valid with values 40..199 in order; frame_done on the value-199 beat.
- Write 100 samples, then frame_start → ignored: frame_busy stays 0 and there is no ddr_read.
- Write 600 samples, then frame_start → read addresses 440..511 then 0..87; values 440..599.
- Continuous in_valid during a frame read → ddr_read && ddr_write never both high; all samples stored at consecutive addresses; frame values are correct.
- Force ddr_waitrequest high for 3 cycles after the 10th read → address, read and write signals held; no skipped or duplicated address; 160 outputs.
- Assert rst after the 50th out_valid → all outputs 0; no further out_valid; a subsequent frame_start is ignored until 160 new samples have been written.
